// File: rtl/instrumentation_trip_latch.sv
// Per-channel trip qualifier: mode gating, debounce over consecutive samples, latch until operator reset.
// Latency: one cycle from accepted sample to trip_out/out_valid.
// Backpressure: one-deep output register; sample_ready = !out_valid | out_ready, so a stalled result holds.
module instrumentation_trip_latch #(
    parameter int NChannels = 3,
    parameter int Debounce  = 4,
    parameter int CntW      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic [NChannels-1:0]   sensor_trips,
    input  logic [2*NChannels-1:0] modes,
    input  logic                   reset_trip,
    input  logic [NChannels-1:0]   reset_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NChannels-1:0]   trip_out
);

    // Channel mode; the reserved encoding is treated exactly like bypass.
    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_OPERATE = 2'd1,
        MODE_FORCE   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    // Counter value at which the next qualifying sample completes the debounce.
    localparam logic [CntW-1:0] DebLast = CntW'(Debounce - 1);

    // All per-channel state is indexed by bit position, which already follows
    // the trip generator's channel-0-at-MSB ordering, so no reordering is needed.
    logic [NChannels-1:0]           latch_q, latch_d;
    logic [NChannels-1:0][CntW-1:0] cnt_q, cnt_d;
    logic                           out_valid_q, out_valid_d;
    logic [NChannels-1:0]           trip_out_q, trip_out_d;

    logic                           accept;
    logic [NChannels-1:0]           raw;
    logic [NChannels-1:0]           forced;

    assign sample_ready = !out_valid_q || out_ready;
    assign accept       = sample_valid && sample_ready;
    assign out_valid    = out_valid_q;
    assign trip_out     = trip_out_q;

    // Decode the current-cycle raw trip per channel from its mode and sensor bit.
    always_comb begin
        raw    = '0;
        forced = '0;
        for (int b = 0; b < NChannels; b++) begin
            mode_t m;
            m         = mode_t'(modes[2*b+1 -: 2]);
            forced[b] = (m == MODE_FORCE);
            raw[b]    = forced[b] || ((m == MODE_OPERATE) && sensor_trips[b]);
        end
    end

    // Next latch/counter state: operator reset first, then the accepted sample
    // is applied to the post-reset state so a reset channel with raw=0 stays clear.
    always_comb begin
        latch_d = latch_q;
        cnt_d   = cnt_q;
        for (int b = 0; b < NChannels; b++) begin
            // A reset against a still-active raw trip is ignored for that channel.
            if (reset_trip && reset_mask[b] && !raw[b]) begin
                latch_d[b] = 1'b0;
                cnt_d[b]   = '0;
            end

            // Latched channels ignore samples and freeze their counter.
            if (accept && !latch_d[b]) begin
                if (raw[b] && forced[b]) begin
                    // Maintenance forced trip bypasses the debounce.
                    latch_d[b] = 1'b1;
                    cnt_d[b]   = '0;
                end else if (raw[b]) begin
                    if (cnt_d[b] == DebLast) begin
                        latch_d[b] = 1'b1;
                        cnt_d[b]   = '0;
                    end else begin
                        cnt_d[b] = cnt_d[b] + 1'b1;
                    end
                end else begin
                    // Any non-qualifying sample restarts the consecutive run.
                    cnt_d[b] = '0;
                end
            end
        end
    end

    // Output register: load on accept, drop valid on a consume without a new accept.
    always_comb begin
        out_valid_d = out_valid_q;
        trip_out_d  = trip_out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            trip_out_d  = latch_d;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; async reset also discards any undelivered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            trip_out_q  <= '0;
        end else begin
            latch_q     <= latch_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            trip_out_q  <= trip_out_d;
        end
    end

endmodule

// File: tb/tb_instrumentation_trip_latch.sv
module tb_instrumentation_trip_latch;

    localparam int N = 3;

    logic           clk;
    logic           rst;
    logic           sample_valid;
    logic           sample_ready;
    logic [N-1:0]   sensor_trips;
    logic [2*N-1:0] modes;
    logic           reset_trip;
    logic [N-1:0]   reset_mask;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   trip_out;

    int checks;
    int errors;

    instrumentation_trip_latch #(
        .NChannels(N),
        .Debounce (4),
        .CntW     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sensor_trips(sensor_trips),
        .modes       (modes),
        .reset_trip  (reset_trip),
        .reset_mask  (reset_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .trip_out    (trip_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs were set before, outputs are observed 2ns after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Async reset pulse applied between edges; outputs must clear while rst is high.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chkv({tag, "_trip"}, trip_out, 3'b000);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sensor_trips = '0;
        modes        = '0;
        reset_trip   = 1'b0;
        reset_mask   = '0;
        out_ready    = 1'b1;

        // Reset state
        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chkv("rst_trip_out", trip_out, 3'b000);
        rst = 1'b0;
        #1;
        chk1("rst_sample_ready", sample_ready, 1'b1);
        step();
        chk1("idle_out_valid", out_valid, 1'b0);

        // Debounce to latch: ch0 qualifies for 4 consecutive samples
        modes        = 6'b01_01_01;
        sensor_trips = 3'b100;
        sample_valid = 1'b1;
        step(); chkv("deb_s1", trip_out, 3'b000); chk1("deb_s1_valid", out_valid, 1'b1);
        step(); chkv("deb_s2", trip_out, 3'b000);
        step(); chkv("deb_s3", trip_out, 3'b000);
        step(); chkv("deb_s4", trip_out, 3'b100); chk1("deb_s4_valid", out_valid, 1'b1);
        sensor_trips = 3'b000;
        step(); chkv("deb_s5_held_latch", trip_out, 3'b100);

        // Reset against an active raw trip is ignored
        sample_valid = 1'b0;
        sensor_trips = 3'b100;
        reset_trip   = 1'b1;
        reset_mask   = 3'b100;
        step();
        chk1("consume_clears_valid", out_valid, 1'b0);
        reset_trip   = 1'b0;
        reset_mask   = 3'b000;
        sample_valid = 1'b1;
        step(); chkv("rst_ignored_raw1", trip_out, 3'b100);

        // Raw now 0: reset plus a simultaneous sample clears the channel
        sensor_trips = 3'b000;
        reset_trip   = 1'b1;
        reset_mask   = 3'b100;
        step(); chkv("rst_with_sample", trip_out, 3'b000);
        reset_trip = 1'b0;
        reset_mask = 3'b000;

        // Glitch rejection on ch1: 1,1,1,0,1,1,1 never latches
        sensor_trips = 3'b010; step(); chkv("glitch_1", trip_out, 3'b000);
        step(); chkv("glitch_2", trip_out, 3'b000);
        step(); chkv("glitch_3", trip_out, 3'b000);
        sensor_trips = 3'b000; step(); chkv("glitch_4", trip_out, 3'b000);
        sensor_trips = 3'b010; step(); chkv("glitch_5", trip_out, 3'b000);
        step(); chkv("glitch_6", trip_out, 3'b000);
        step(); chkv("glitch_7", trip_out, 3'b000);
        // fourth consecutive qualifying sample after the gap latches ch1
        step(); chkv("glitch_8_latch", trip_out, 3'b010);

        // Fresh state for the mode tests
        sample_valid = 1'b0;
        pulse_reset("arst_a");

        // Forced trip and bypass: ch0=forced, ch1=bypass, ch2=reserved
        modes        = 6'b10_00_11;
        sensor_trips = 3'b011;
        sample_valid = 1'b1;
        step(); chkv("force_first", trip_out, 3'b100);
        // reserved mode must not debounce even after 4+ samples
        for (int i = 0; i < 4; i++) begin
            step();
            chkv("force_rsvd_bypass", trip_out, 3'b100);
        end

        // Back-pressure: output held, no accept, counters frozen
        modes        = 6'b01_01_01;
        sensor_trips = 3'b011;
        out_ready    = 1'b0;
        #1;
        chk1("bp_ready_low", sample_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("bp_hold_valid", out_valid, 1'b1);
            chkv("bp_hold_trip", trip_out, 3'b100);
            chk1("bp_hold_ready", sample_ready, 1'b0);
        end
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        #1;
        chk1("bp_release_ready", sample_ready, 1'b1);
        step(); chk1("bp_consumed", out_valid, 1'b0);
        // ch1/ch2 must still need all 4 samples (no counting during the stall)
        sample_valid = 1'b1;
        step(); chkv("bp_post_s1", trip_out, 3'b100);
        step(); chkv("bp_post_s2", trip_out, 3'b100);
        step(); chkv("bp_post_s3", trip_out, 3'b100);
        step(); chkv("bp_post_s4", trip_out, 3'b111);

        // Async reset mid-debounce on ch2
        sample_valid = 1'b0;
        pulse_reset("arst_b");
        sensor_trips = 3'b001;
        sample_valid = 1'b1;
        step(); chkv("mid_s1", trip_out, 3'b000);
        step(); chkv("mid_s2", trip_out, 3'b000);
        step(); chkv("mid_s3", trip_out, 3'b000);
        sample_valid = 1'b0;
        pulse_reset("arst_mid");
        sample_valid = 1'b1;
        step(); chkv("post_rst_s1", trip_out, 3'b000);
        step(); chkv("post_rst_s2", trip_out, 3'b000);
        step(); chkv("post_rst_s3", trip_out, 3'b000);
        step(); chkv("post_rst_s4", trip_out, 3'b001);
        sample_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instrumentation_trip_latch.md
Name: instrumentation_trip_latch

Overview:
- Sequential stage directly downstream of the per-channel sensor trip generator (temperature, pressure, saturation channels).
- Combines each sampled sensor trip bit with its channel mode and debounces it over consecutive samples.
- Latches each channel trip until an explicit operator reset.
- Presents the latched trip vector to the voting logic over a valid/ready handshake.

Parameters:
- NChannels, 3: number of trip channels. Channel 0 is packed at the MSB end, matching the trip generator's output ordering.
- Debounce, 4: consecutive qualifying samples needed to latch a trip. Legal range 1..7.
- CntW, 3: debounce counter width. Must satisfy 2^CntW > Debounce.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_valid  input  1  the sensor_trips/modes sample is valid.
- sample_ready  output  1  the stage can accept a sample this cycle.
- sensor_trips  input  NChannels  raw per-channel trip bits; channel c is at bit NChannels-1-c.
- modes  input  2*NChannels  per-channel mode; channel c is at bits [2*(NChannels-c)-1 -: 2].
- reset_trip  input  1  single-cycle operator trip-reset strobe.
- reset_mask  input  NChannels  channels targeted by reset_trip (same bit ordering).
- out_valid  output  1  trip_out holds a new result.
- out_ready  input  1  the voting stage consumes the result.
- trip_out  output  NChannels  latched trip vector (same bit ordering).

Behaviour:
- Reset: out_valid=0, trip_out=0, all latches=0, all counters=0. sample_ready=1 once reset is released.
- Mode encoding: 0=bypass, 1=operate, 2=forced trip (maintenance), 3=reserved. Mode 3 behaves as bypass.
- Per-channel raw trip: raw[c] = (mode==2) | (mode==1 & sensor_trips[c]).
- Accept: a sample is accepted when sample_valid & sample_ready.
- Ready: sample_ready = !out_valid | out_ready. This is a one-deep output register with no combinational path from sample_valid.
- On accept, per channel c that is not latched:
  - raw[c]=1 and mode==2: latch[c] sets immediately (no debounce) and cnt[c] clears.
  - raw[c]=1 and mode==1: cnt[c] increments. When cnt[c]+1 == Debounce, latch[c] sets and cnt[c] clears.
  - raw[c]=0: cnt[c] clears. A trip requires Debounce strictly consecutive accepted samples.
- Latched channels:
  - Ignore samples and stay latched.
  - Counters do not advance while latched.
- Cycles without an accepted sample change no counter.
- Trip reset:
  - When reset_trip=1, each channel with reset_mask[c]=1 clears latch[c] and cnt[c].
  - This happens only if raw[c], evaluated from the current-cycle sensor_trips/modes, is 0. A reset against an active raw trip is ignored for that channel.
  - reset_trip is honoured regardless of sample_valid.
- Simultaneous reset_trip and accept in the same cycle: apply the reset first, then the sample update using the post-reset state. A reset channel with raw=0 therefore stays clear with cnt=0.
- Output update:
  - The edge that accepts a sample loads trip_out with the post-update latch vector and sets out_valid=1.
  - Result is visible in the next cycle; latency is 1 cycle.
- Output consumption: out_valid & out_ready with no new accept clears out_valid. Accept and consume in the same cycle keeps out_valid=1 with the new vector.
- Back-pressure: while out_valid & !out_ready, trip_out and out_valid hold stable and sample_ready=0.
  - Latch changes caused by reset_trip are not reflected in a held trip_out.
  - They appear with the next accepted sample.
- Counter arithmetic is unsigned and never exceeds Debounce-1, so it cannot wrap.
- Mode changes take effect on the next accepted sample. Changing mode does not clear an existing latch; only a reset does.
- Async rst asserted mid-operation returns every register to its reset value immediately, including a pending undelivered output.

Test Plan:
- Debounce to latch: modes all 1, out_ready=1, sensor_trips=100 for 4 consecutive accepts -> trip_out=000,000,000,100. The 5th sample with sensor_trips=000 still gives 100.
- Glitch rejection: channel 1 pattern 1,1,1,0,1,1,1 (mode 1) -> channel 1 bit (trip_out=000) stays 0 throughout.
- Forced trip and bypass: modes ch0=2, ch1=0, ch2=3 with sensor_trips=011 -> trip_out=100 on the first output.
- Reset rules:
  - Latched ch0 with raw still 1: reset_trip, mask=100 -> latch unchanged.
  - After raw goes 0, reset_trip plus a simultaneous sample -> trip_out=000.
- Back-pressure: out_ready=0 after one output -> sample_ready=0 and trip_out held for 10 cycles. Then out_ready=1 -> one consume, sample_ready=1 the same cycle.
- Async reset mid-debounce: after 3 qualifying samples assert rst -> all outputs 0. Four fresh samples are then needed to latch.
